// File: rtl/cache_line_bus_bridge.sv
// -----------------------------------------------------------------------------
// cache_line_bus_bridge
//
// Sits between the L1 cache line-memory port and the 32-bit system bus.
// A line read becomes a burst of BEATS word reads, which may be pipelined up to
// MAX_OUTSTANDING deep. Responses come back in order and are assembled into a
// fill buffer. A line write becomes BEATS posted word writes. Completion of
// either kind is signalled to the cache with a one-cycle mem_ready pulse.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   mem_address        line address from the cache (offset bits ignored)
//   mem_write_data     line to write
//   mem_write_enable   level write request, held until mem_ready
//   mem_read_enable    level read request, held until mem_ready (has priority)
//   mem_read_data      last completed fill line
//   mem_ready          one-cycle completion pulse
//   bus_req_valid/ready/we, bus_addr, bus_wdata   word request channel
//   bus_rvalid, bus_rdata                         in-order read responses
// -----------------------------------------------------------------------------
module cache_line_bus_bridge #(
    parameter int LINE_BITS       = 512,
    parameter int WORD_BITS       = 32,
    parameter int ADDR_BITS       = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] mem_address,
    input  logic [LINE_BITS-1:0] mem_write_data,
    input  logic                 mem_write_enable,
    input  logic                 mem_read_enable,
    output logic [LINE_BITS-1:0] mem_read_data,
    output logic                 mem_ready,
    output logic                 bus_req_valid,
    input  logic                 bus_req_ready,
    output logic                 bus_req_we,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic [WORD_BITS-1:0] bus_wdata,
    input  logic                 bus_rvalid,
    input  logic [WORD_BITS-1:0] bus_rdata
);

    localparam int BEATS       = LINE_BITS / WORD_BITS;
    localparam int CNT_W       = $clog2(BEATS);
    localparam int OUT_W       = $clog2(MAX_OUTSTANDING) + 1;
    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
    localparam int WORD_SHIFT  = $clog2(WORD_BITS / 8);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [ADDR_BITS-1:0] base_reg, base_next;
    logic [LINE_BITS-1:0] wdata_reg, wdata_next;
    logic [CNT_W-1:0]     issue_cnt_reg, issue_cnt_next;
    logic                 issue_done_reg, issue_done_next;
    logic [CNT_W-1:0]     rcv_cnt_reg, rcv_cnt_next;
    logic [OUT_W-1:0]     outstanding_reg, outstanding_next;
    logic [LINE_BITS-1:0] fill_reg, fill_next;
    logic [LINE_BITS-1:0] read_data_reg, read_data_next;

    logic                 req_valid;
    logic                 req_fire;
    logic                 rsp_ok;
    logic                 last_issue;
    logic                 last_rsp;
    logic [WORD_BITS-1:0] wr_word [BEATS];

    // Line offset bits of the cache address carry no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_address[OFFSET_BITS-1:0];

    // -------------------------------------------------------------------------
    // Request channel
    // -------------------------------------------------------------------------
    // In RD the request only drops after a handshake (issue_cnt or the
    // outstanding count can only move the gate closed on a transfer), so an
    // offered beat is never withdrawn before it is accepted.
    always_comb begin
        req_valid = 1'b0;
        case (state_reg)
            ST_RD:   req_valid = !issue_done_reg &&
                                 (outstanding_reg < OUT_W'(MAX_OUTSTANDING));
            ST_WR:   req_valid = 1'b1;
            default: req_valid = 1'b0;
        endcase
    end

    assign req_fire   = req_valid && bus_req_ready;
    // Responses outside a read, or with nothing outstanding, are dropped.
    assign rsp_ok     = bus_rvalid && (state_reg == ST_RD) && (outstanding_reg != '0);
    assign last_issue = (issue_cnt_reg == CNT_W'(BEATS - 1));
    assign last_rsp   = (rcv_cnt_reg == CNT_W'(BEATS - 1));

    // Word slicing of the captured write line and per-slot fill update.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
        assign wr_word[gi] = wdata_reg[gi*WORD_BITS +: WORD_BITS];
        assign fill_next[gi*WORD_BITS +: WORD_BITS] =
            (rsp_ok && (rcv_cnt_reg == CNT_W'(gi))) ? bus_rdata
                                                     : fill_reg[gi*WORD_BITS +: WORD_BITS];
    end

    assign bus_req_valid = req_valid;
    assign bus_req_we    = (state_reg == ST_WR);
    assign bus_addr      = base_reg + (ADDR_BITS'(issue_cnt_reg) << WORD_SHIFT);
    assign bus_wdata     = wr_word[issue_cnt_reg];
    assign mem_ready     = (state_reg == ST_DONE);
    assign mem_read_data = read_data_reg;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        base_next        = base_reg;
        wdata_next       = wdata_reg;
        issue_cnt_next   = issue_cnt_reg;
        issue_done_next  = issue_done_reg;
        rcv_cnt_next     = rcv_cnt_reg;
        outstanding_next = outstanding_reg;
        read_data_next   = read_data_reg;

        case (state_reg)
            ST_IDLE: begin
                if (mem_read_enable || mem_write_enable) begin
                    base_next        = {mem_address[ADDR_BITS-1:OFFSET_BITS],
                                        {OFFSET_BITS{1'b0}}};
                    issue_cnt_next   = '0;
                    issue_done_next  = 1'b0;
                    rcv_cnt_next     = '0;
                    outstanding_next = '0;
                    if (mem_read_enable) begin
                        state_next = ST_RD;
                    end else begin
                        wdata_next = mem_write_data;
                        state_next = ST_WR;
                    end
                end
            end

            ST_RD: begin
                if (req_fire) begin
                    issue_cnt_next = issue_cnt_reg + CNT_W'(1);
                    // The 4-bit counter wraps after the last beat; this flag
                    // stops issue instead.
                    if (last_issue) begin
                        issue_done_next = 1'b1;
                    end
                end
                case ({req_fire, rsp_ok})
                    2'b10:   outstanding_next = outstanding_reg + OUT_W'(1);
                    2'b01:   outstanding_next = outstanding_reg - OUT_W'(1);
                    default: outstanding_next = outstanding_reg;
                endcase
                if (rsp_ok) begin
                    rcv_cnt_next = rcv_cnt_reg + CNT_W'(1);
                    if (last_rsp) begin
                        // Publish the completed line on entry to DONE so it is
                        // already valid while mem_ready is high.
                        read_data_next = fill_next;
                        state_next     = ST_DONE;
                    end
                end
            end

            ST_WR: begin
                if (req_fire) begin
                    issue_cnt_next = issue_cnt_reg + CNT_W'(1);
                    if (last_issue) begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_reg        <= '0;
            wdata_reg       <= '0;
            issue_cnt_reg   <= '0;
            issue_done_reg  <= 1'b0;
            rcv_cnt_reg     <= '0;
            outstanding_reg <= '0;
            fill_reg        <= '0;
            read_data_reg   <= '0;
        end else begin
            base_reg        <= base_next;
            wdata_reg       <= wdata_next;
            issue_cnt_reg   <= issue_cnt_next;
            issue_done_reg  <= issue_done_next;
            rcv_cnt_reg     <= rcv_cnt_next;
            outstanding_reg <= outstanding_next;
            fill_reg        <= fill_next;
            read_data_reg   <= read_data_next;
        end
    end

`ifndef SYNTHESIS
    // A response with no read in flight is a bus protocol violation.
    always @(posedge clk) begin
        if (!reset && bus_rvalid) begin
            assert ((state_reg == ST_RD) && (outstanding_reg != '0))
                else $error("bus_rvalid with no outstanding read request");
        end
    end
`endif

endmodule

// File: tb/tb_cache_line_bus_bridge.sv
module tb_cache_line_bus_bridge;

    localparam int LB = 512;
    localparam int WB = 32;
    localparam int AB = 32;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AB-1:0] mem_address = '0;
    logic [LB-1:0] mem_write_data = '0;
    logic          mem_write_enable = 1'b0;
    logic          mem_read_enable = 1'b0;
    logic [LB-1:0] mem_read_data;
    logic          mem_ready;
    logic          bus_req_valid;
    logic          bus_req_ready;
    logic          bus_req_we;
    logic [AB-1:0] bus_addr;
    logic [WB-1:0] bus_wdata;
    logic          bus_rvalid;
    logic [WB-1:0] bus_rdata;

    cache_line_bus_bridge #(
        .LINE_BITS(LB), .WORD_BITS(WB), .ADDR_BITS(AB), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_read_data(mem_read_data), .mem_ready(mem_ready),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_we(bus_req_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } req_t;
    typedef struct { logic [511:0] line; int lat; } done_t;
    typedef struct { int due; logic [31:0] data; } rsp_t;

    req_t  exp_req_q[$];
    done_t exp_done_q[$];
    rsp_t  rsp_q[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          hs_count = 0;
    int          cur_out = 0;
    int          max_out = 0;
    int          rsp_delay = 1;
    bit          ready_random = 1'b0;
    bit          done_seen = 1'b0;
    logic [31:0] rd_pat = '0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus model: request-ready pattern and in-order delayed read responses.
    initial begin
        bus_rvalid    = 1'b0;
        bus_rdata     = '0;
        bus_req_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus_req_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_rvalid = 1'b0;
            if (reset) begin
                rsp_q.delete();
            end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                rsp_t r;
                r = rsp_q.pop_front();
                bus_rvalid = 1'b1;
                bus_rdata  = r.data;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic        prev_pend;
        logic [31:0] prev_addr, prev_wdata;
        logic        prev_we;
        req_t        r;
        done_t       d;
        prev_pend = 1'b0;
        prev_addr = '0; prev_wdata = '0; prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_pend = 1'b0;
                cur_out   = 0;
            end else begin
                if (prev_pend) begin
                    check("hold_valid", 512'(bus_req_valid), 512'(1'b1));
                    check("hold_addr", 512'(bus_addr), 512'(prev_addr));
                    check("hold_we", 512'(bus_req_we), 512'(prev_we));
                    check("hold_wdata", 512'(bus_wdata), 512'(prev_wdata));
                end
                if (bus_rvalid) cur_out--;
                if (bus_req_valid && bus_req_ready) begin
                    hs_count++;
                    $display("req we=%0d addr=%h data=%h", bus_req_we, bus_addr, bus_wdata);
                    if (!bus_req_we) begin
                        cur_out++;
                        rsp_q.push_back('{due: cyc + rsp_delay,
                                          data: rd_pat + ((bus_addr >> 2) & 32'hF)});
                    end
                    if (exp_req_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_req: got addr %h we %0d want none", bus_addr, bus_req_we);
                    end else begin
                        r = exp_req_q.pop_front();
                        check("req_addr", 512'(bus_addr), 512'(r.addr));
                        check("req_we", 512'(bus_req_we), 512'(r.we));
                        if (r.we) check("req_wdata", 512'(bus_wdata), 512'(r.wdata));
                    end
                end
                if (cur_out > max_out) max_out = cur_out;
                prev_pend  = bus_req_valid && !bus_req_ready;
                prev_addr  = bus_addr;
                prev_we    = bus_req_we;
                prev_wdata = bus_wdata;
                if (mem_ready) begin
                    done_seen = 1'b1;
                    $display("mem_ready cycle=%0d word0=%h word15=%h",
                             cyc - start_cyc + 1, mem_read_data[31:0], mem_read_data[511:480]);
                    if (exp_done_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_ready: got pulse want none");
                    end else begin
                        d = exp_done_q.pop_front();
                        check("read_line", mem_read_data, d.line);
                        if (d.lat >= 0) check("latency", 512'(cyc - start_cyc + 1), 512'(d.lat));
                    end
                end
            end
        end
    end

    task automatic push_reqs(input logic [31:0] base, input logic we, input logic [511:0] wline);
        for (int k = 0; k < 16; k++) begin
            exp_req_q.push_back('{addr: base + 32'(4 * k), we: we,
                                  wdata: we ? wline[k*32 +: 32] : 32'h0});
        end
    endtask

    function automatic logic [511:0] pat_line(input logic [31:0] base, input logic [31:0] step);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + step * 32'(k);
        return l;
    endfunction

    // Raises the enables, waits for mem_ready, drops them on the sampling edge.
    task automatic run_burst(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [511:0] wline);
        @(posedge clk);
        #1;
        done_seen        = 1'b0;
        mem_address      = addr;
        mem_write_data   = wline;
        mem_read_enable  = rd;
        mem_write_enable = wr;
        start_cyc        = cyc;
        for (int i = 0; i < 2000 && !done_seen; i++) @(posedge clk);
        #1;
        if (!done_seen) begin
            total++;
            bad++;
            $display("FAIL burst_timeout: got no mem_ready want pulse at addr %h", addr);
        end
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
    endtask

    initial begin
        logic [511:0] line1, line3, line5, line6, wl2, wl4, junk;
        int h0;

        line1 = pat_line(32'hA000_0000, 32'h1);
        wl2   = pat_line(32'h0, 32'h1111);
        line3 = pat_line(32'hB000_0000, 32'h1);
        wl4   = pat_line(32'hC0DE_0000, 32'h1);
        line5 = pat_line(32'hD000_0000, 32'h1);
        line6 = pat_line(32'hE000_0000, 32'h1);
        junk  = {16{32'hDEAD_BEEF}};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 512'(bus_req_valid), 512'(0));
        check("rst_we", 512'(bus_req_we), 512'(0));
        check("rst_addr", 512'(bus_addr), 512'(0));
        check("rst_wdata", 512'(bus_wdata), 512'(0));
        check("rst_ready", 512'(mem_ready), 512'(0));
        check("rst_rdata", mem_read_data, 512'(0));
        @(posedge clk);
        #3;
        reset = 1'b0;

        // 1: read, always ready, 1-cycle response
        rd_pat = 32'hA000_0000; rsp_delay = 1;
        push_reqs(32'h1200, 1'b0, '0);
        exp_done_q.push_back('{line: line1, lat: 19});
        run_burst(1'b1, 1'b0, 32'h0000_1234, '0);

        // 2: write-through, read data unchanged
        push_reqs(32'h440, 1'b1, wl2);
        exp_done_q.push_back('{line: line1, lat: 18});
        run_burst(1'b0, 1'b1, 32'h0000_0440, wl2);

        // 3: read with 10-cycle response delay, outstanding limit
        rd_pat = 32'hB000_0000; rsp_delay = 10; max_out = 0;
        push_reqs(32'h2000, 1'b0, '0);
        exp_done_q.push_back('{line: line3, lat: -1});
        run_burst(1'b1, 1'b0, 32'h0000_203C, '0);
        check("max_outstanding", 512'(max_out), 512'(4));

        // 4: write with random ready stalls
        ready_random = 1'b1; rsp_delay = 1;
        push_reqs(32'h8080, 1'b1, wl4);
        exp_done_q.push_back('{line: line3, lat: -1});
        run_burst(1'b0, 1'b1, 32'h0000_8080, wl4);
        ready_random = 1'b0;

        // 5: both enables, read wins
        rd_pat = 32'hD000_0000;
        push_reqs(32'h3000, 1'b0, '0);
        exp_done_q.push_back('{line: line5, lat: 19});
        run_burst(1'b1, 1'b1, 32'h0000_3000, junk);

        // 6: reset after 7 read beats, then a clean read
        rd_pat = 32'hE000_0000;
        push_reqs(32'h4000, 1'b0, '0);
        @(posedge clk);
        #1;
        mem_address = 32'h0000_4000; mem_read_enable = 1'b1;
        h0 = hs_count;
        for (int i = 0; i < 200 && hs_count < h0 + 7; i++) @(posedge clk);
        check("beats_before_reset", 512'(hs_count - h0), 512'(7));
        #1;
        reset = 1'b1;
        #1;
        check("async_valid", 512'(bus_req_valid), 512'(0));
        check("async_addr", 512'(bus_addr), 512'(0));
        check("async_ready", 512'(mem_ready), 512'(0));
        check("async_rdata", mem_read_data, 512'(0));
        mem_read_enable = 1'b0;
        exp_req_q.delete();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        push_reqs(32'h4000, 1'b0, '0);
        exp_done_q.push_back('{line: line6, lat: 19});
        run_burst(1'b1, 1'b0, 32'h0000_4000, '0);

        repeat (20) @(posedge clk);
        check("req_queue_empty", 512'(exp_req_q.size()), 512'(0));
        check("done_queue_empty", 512'(exp_done_q.size()), 512'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
